ps_rgb2gray: RTL and testbench

//  Converts an RGB565 pixel stream from the camera capture path into the 8-bit

---
 rtl/ps_rgb2gray.sv | 155 +++++++++++++++
 tb/tb_ps_rgb2gray.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ps_rgb2gray.sv
// ---------------------------------------------------------------------------
// ps_rgb2gray
// Converts an RGB565 pixel stream into 8-bit luma for the Gaussian stage.
// The pipeline has three stages: expand, multiply, and sum/round. Stage 2 is
// also the output register. Each stage advances with a valid/ready rule that
// collapses bubbles, so downstream backpressure reaches the input without
// dropping or repeating pixels.
//
// Ports:
//   i_clk     system clock, rising edge
//   i_rstn    asynchronous active-low reset
//   i_enable  1 = luma conversion, 0 = green-channel passthrough
//   i_data    RGB565 pixel {R[4:0], G[5:0], B[4:0]}
//   i_valid   i_data is valid
//   o_ready   block accepts i_data this cycle (combinational)
//   o_data    grayscale pixel (registered)
//   o_valid   o_data is valid (registered)
//   i_ready   downstream accepts o_data
// ---------------------------------------------------------------------------
module ps_rgb2gray #(
  parameter int unsigned COEF_R = 77,
  parameter int unsigned COEF_G = 150,
  parameter int unsigned COEF_B = 29
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_enable,
  input  logic [15:0] i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_ready
);

  localparam logic [15:0] CR = 16'(COEF_R);
  localparam logic [15:0] CG = 16'(COEF_G);
  localparam logic [15:0] CB = 16'(COEF_B);

  // stage 0: expanded colour channels plus the mode bit sampled with the pixel
  logic        v0_q, v0_d;
  logic [7:0]  r8_q, r8_d, g8_q, g8_d, b8_q, b8_d;
  logic        en0_q, en0_d;
  // stage 1: weighted products; G8 and the mode bit travel alongside them
  logic        v1_q, v1_d;
  logic [15:0] pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
  logic [7:0]  g81_q, g81_d;
  logic        en1_q, en1_d;
  // stage 2: output register
  logic        v2_q, v2_d;
  logic [7:0]  data_q, data_d;

  logic        ld0_s, ld1_s, ld2_s;
  logic [16:0] sum_s;
  logic [7:0]  luma_s;

  // Load enables: a stage may load when it is empty or when its contents move on.
  always_comb begin
    ld2_s   = !v2_q || i_ready;
    ld1_s   = !v1_q || ld2_s;
    ld0_s   = !v0_q || ld1_s;
    o_ready = ld0_s;
  end

  // Rounded luma. The weights sum to 256, so the result always fits in 8 bits.
  always_comb begin
    sum_s  = {1'b0, pr_q} + {1'b0, pg_q} + {1'b0, pb_q} + 17'd128;
    luma_s = 8'(sum_s >> 5'd8);
  end

  // Next-state logic. Each stage holds its data and valid bit unless it loads.
  // Data registers load only when a valid pixel arrives, so o_data stays stable
  // across bubbles.
  always_comb begin
    v0_d   = v0_q;   r8_d  = r8_q;  g8_d  = g8_q;  b8_d = b8_q; en0_d = en0_q;
    v1_d   = v1_q;   pr_d  = pr_q;  pg_d  = pg_q;  pb_d = pb_q;
    g81_d  = g81_q;  en1_d = en1_q;
    v2_d   = v2_q;   data_d = data_q;

    if (ld0_s) begin
      v0_d = i_valid;
      if (i_valid) begin
        // Replicate the MSBs so that full scale maps to 8'hFF.
        r8_d  = {i_data[15:11], i_data[15:13]};
        g8_d  = {i_data[10:5],  i_data[10:9]};
        b8_d  = {i_data[4:0],   i_data[4:2]};
        en0_d = i_enable;
      end else begin
        en0_d = en0_q;
      end
    end else begin
      v0_d = v0_q;
    end

    if (ld1_s) begin
      v1_d = v0_q;
      if (v0_q) begin
        pr_d  = CR * {8'd0, r8_q};
        pg_d  = CG * {8'd0, g8_q};
        pb_d  = CB * {8'd0, b8_q};
        g81_d = g8_q;
        en1_d = en0_q;
      end else begin
        en1_d = en1_q;
      end
    end else begin
      v1_d = v1_q;
    end

    if (ld2_s) begin
      v2_d = v1_q;
      if (v1_q) begin
        data_d = en1_q ? luma_s : g81_q;
      end else begin
        data_d = data_q;
      end
    end else begin
      v2_d = v2_q;
    end
  end

  // Pipeline registers. Reset clears the valids and the output data. The data
  // registers of the inner stages need no reset because they are always
  // qualified by their valid bits.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      data_q <= 8'd0;
    end else begin
      v0_q   <= v0_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      data_q <= data_d;
    end
  end

  // Datapath registers for stages 0 and 1.
  always_ff @(posedge i_clk) begin
    r8_q  <= r8_d;
    g8_q  <= g8_d;
    b8_q  <= b8_d;
    en0_q <= en0_d;
    pr_q  <= pr_d;
    pg_q  <= pg_d;
    pb_q  <= pb_d;
    g81_q <= g81_d;
    en1_q <= en1_d;
  end

  assign o_data  = data_q;
  assign o_valid = v2_q;

endmodule

// File: tb/tb_ps_rgb2gray.sv
// ---------------------------------------------------------------------------
// tb_ps_rgb2gray
// Self-checking bench for ps_rgb2gray. Inputs are driven on the falling edge
// and outputs are sampled 1 ns later. Each accepted pixel pushes its expected
// value onto a scoreboard queue. Each output transfer pops the queue and
// compares the result.
// ---------------------------------------------------------------------------
module tb_ps_rgb2gray;

  logic        clk, rst_n;
  logic        i_enable, i_valid, i_ready;
  logic [15:0] i_data;
  logic        o_ready, o_valid;
  logic [7:0]  o_data;

  ps_rgb2gray dut (
    .i_clk   (clk),
    .i_rstn  (rst_n),
    .i_enable(i_enable),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] exp;
    int         cyc;
    bit         lat;
  } sb_t;

  typedef struct {
    logic [15:0] data;
    logic        en;
    logic [7:0]  exp;
  } vec_t;

  sb_t  q[$];
  vec_t vecs[11];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_out   = 0;
  int   n_acc   = 0;
  bit   acc;

  // Independent reference: expand RGB565 to 8 bits per channel, then apply
  // weights 77/150/29 with rounding.
  function automatic logic [7:0] model(input logic [15:0] d, input logic en);
    int r8, g8, b8;
    r8 = {d[15:11], d[15:13]};
    g8 = {d[10:5], d[10:9]};
    b8 = {d[4:0], d[4:2]};
    if (en) return 8'((77 * r8 + 150 * g8 + 29 * b8 + 128) / 256);
    else    return 8'(g8);
  endfunction

  // Runs one clock cycle: drive the inputs, check o_ready, pop and compare
  // any output, and push any accepted pixel.
  task automatic step(input logic v, input logic [15:0] d, input logic en,
                      input logic rdy, input logic [7:0] exp, input bit lat);
    sb_t e;
    @(negedge clk);
    i_valid = v; i_data = d; i_enable = en; i_ready = rdy;
    #1;
    n_tests++;
    if (o_ready !== ((q.size() < 3) || rdy)) begin
      n_fail++;
      $display("FAIL o_ready cyc=%0d got=%b want=%b", cyc, o_ready, ((q.size() < 3) || rdy));
    end
    if (o_valid && rdy) begin
      n_out++;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_out cyc=%0d got=%h want=none", cyc, o_data);
      end else begin
        e = q.pop_front();
        if (o_data !== e.exp) begin
          n_fail++;
          $display("FAIL data cyc=%0d got=%h want=%h", cyc, o_data, e.exp);
        end
        if (e.lat) begin
          n_tests++;
          if (cyc - e.cyc != 3) begin
            n_fail++;
            $display("FAIL latency cyc=%0d got=%0d want=3", cyc, cyc - e.cyc);
          end
        end
      end
    end
    acc = v && o_ready;
    if (acc) begin
      n_acc++;
      e.exp = exp; e.cyc = cyc; e.lat = lat;
      q.push_back(e);
    end
    cyc++;
  endtask

  // Lets the pipeline empty within a bounded number of cycles.
  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) step(1'b0, 16'h0, 1'b1, 1'b1, 8'h0, 1'b0);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout got=%0d want=0 pending", q.size());
      q.delete();
    end
  endtask

  initial begin
    logic [15:0] pix;
    int          idx, out0, acc0;
    logic [4:0]  vpat;

    vecs[0]  = '{16'hFFFF, 1'b1, 8'hFF};
    vecs[1]  = '{16'h0000, 1'b1, 8'h00};
    vecs[2]  = '{16'hF800, 1'b1, 8'h4D};
    vecs[3]  = '{16'h07E0, 1'b1, 8'h95};
    vecs[4]  = '{16'h001F, 1'b1, 8'h1D};
    vecs[5]  = '{16'h07E0, 1'b0, 8'hFF};
    vecs[6]  = '{16'hF800, 1'b0, 8'h00};
    vecs[7]  = '{16'h0400, 1'b0, 8'h82};
    vecs[8]  = '{16'hF800, 1'b1, 8'h4D};   // enable toggles between beats
    vecs[9]  = '{16'hF800, 1'b0, 8'h00};
    vecs[10] = '{16'hF800, 1'b1, 8'h4D};

    // Reset held with valid input: no output, data cleared
    rst_n = 1'b0; i_valid = 1'b1; i_data = 16'hFFFF; i_enable = 1'b1; i_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_tests++;
    if (o_valid !== 1'b0 || o_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_out got=%b/%h want=0/00", o_valid, o_data);
    end
    rst_n = 1'b1; i_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got=%b want=1", o_ready);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1, 1'b1, 8'h0, 1'b0);

    // Table of colour and passthrough vectors, one pixel per clock with fixed latency
    for (int i = 0; i < 11; i++) step(1'b1, vecs[i].data, vecs[i].en, 1'b1, vecs[i].exp, 1'b1);
    drain();

    // Backpressure: 10 pixels with a 6-cycle downstream stall
    idx = 0; out0 = n_out;
    for (int c = 0; c < 60 && idx < 10; c++) begin
      pix = 16'h1234 + 16'(idx) * 16'h0841;
      step(1'b1, pix, 1'b1, !(c >= 2 && c < 8), model(pix, 1'b1), 1'b0);
      if (acc) idx++;
    end
    drain();
    n_tests++;
    if (n_out - out0 != 10) begin
      n_fail++;
      $display("FAIL backpressure_count got=%0d want=10", n_out - out0);
    end

    // Bubbles: valid pattern 1,0,1,1,0 with ready toggling 0,1,0,1
    out0 = n_out; acc0 = n_acc; vpat = 5'b01101;
    for (int c = 0; c < 25; c++) begin
      pix = 16'($urandom);
      step(vpat[c % 5], pix, c[2], c[0], model(pix, c[2]), 1'b0);
    end
    drain();
    n_tests++;
    if (n_out - out0 != n_acc - acc0) begin
      n_fail++;
      $display("FAIL bubble_count got=%0d want=%0d", n_out - out0, n_acc - acc0);
    end

    // Reset with three pixels in flight
    for (int c = 0; c < 3; c++) step(1'b1, 16'hFFFF, 1'b1, 1'b0, 8'hFF, 1'b0);
    @(negedge clk);
    i_valid = 1'b0; i_ready = 1'b1; #1;
    rst_n = 1'b0; #1;
    n_tests++;
    if (o_valid !== 1'b0 || o_data !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_out got=%b/%h want=0/00", o_valid, o_data);
    end
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 1'b1, 1'b1, 8'h0, 1'b0);
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_out got=%b want=0", o_valid);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
